// File: rtl/mips_mc_control_if.sv
// Bus between the multicycle control unit and its datapath: the instruction
// register and memory status come in; strobes and mux selects go out.
interface mips_mc_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        ir_write;
  logic        mem_read;
  logic        mem_write;
  logic        iord;
  logic        pc_write;
  logic [1:0]  pc_write_cond;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        ext_op;
  logic [3:0]  alu_control;
  logic [3:0]  state;
  logic        error;

  // Control side
  modport master (
    input  instr, mem_ready,
    output ir_write, mem_read, mem_write, iord, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
           ext_op, alu_control, state, error
  );

  // Datapath side
  modport slave (
    output instr, mem_ready,
    input  ir_write, mem_read, mem_write, iord, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg, reg_write,
           ext_op, alu_control, state, error
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit. Moore FSM with memory wait states (fixed
// latency or ready handshake), a handshake timeout trap and a sticky error.
module mips_mc_control #(
  parameter int MEM_HANDSHAKE = 0,
  parameter int MEM_LATENCY   = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic               clk,
  input  logic               rst,
  mips_mc_control_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I,
    ALU_WB, BRANCH, JUMP, JAL, JR, ERROR
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [7:0] LAT_LAST = 8'(MEM_LATENCY - 1);
  localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

  state_t      st, nxt;
  logic [7:0]  cnt;
  logic        err_q;
  logic [5:0]  op, fn;
  logic        mem_st, done, timeout;
  logic        r_legal, r_shift, i_zext;
  logic [3:0]  r_alu, i_alu;
  logic        unused_instr;

  assign op           = bus.instr[31:26];
  assign fn           = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];

  assign mem_st  = (st == FETCH) || (st == MEMRD) || (st == MEMWR);
  // Access completes on mem_ready in handshake mode, else after a fixed count.
  assign done    = (MEM_HANDSHAKE != 0) ? bus.mem_ready : (cnt == LAT_LAST);
  // mem_ready in the same cycle wins over the timeout (done is checked first).
  assign timeout = (MEM_HANDSHAKE != 0) && (TIMEOUT != 0) && mem_st &&
                   !bus.mem_ready && (cnt == TO_CNT);

  assign bus.state = st;
  assign bus.error = err_q;

  // R-type funct decode: ALU op, shift flag, legality (jr counts as legal).
  always_comb begin
    r_legal = 1'b1;
    r_shift = 1'b0;
    r_alu   = ALU_ADD;
    case (fn)
      6'h20, 6'h21: r_alu = ALU_ADD;
      6'h22, 6'h23: r_alu = ALU_SUB;
      6'h24:        r_alu = ALU_AND;
      6'h25:        r_alu = ALU_OR;
      6'h26:        r_alu = ALU_XOR;
      6'h27:        r_alu = ALU_NOR;
      6'h2A:        r_alu = ALU_SLT;
      6'h00:        begin r_alu = ALU_SLL; r_shift = 1'b1; end
      6'h02:        begin r_alu = ALU_SRL; r_shift = 1'b1; end
      6'h03:        begin r_alu = ALU_SRA; r_shift = 1'b1; end
      6'h08:        r_alu = ALU_ADD;
      default:      r_legal = 1'b0;
    endcase
  end

  // I-type ALU op; logical immediates are zero-extended.
  always_comb begin
    i_zext = 1'b0;
    i_alu  = ALU_ADD;
    case (op)
      6'h0A:   i_alu = ALU_SLT;
      6'h0C:   begin i_alu = ALU_AND; i_zext = 1'b1; end
      6'h0D:   begin i_alu = ALU_OR;  i_zext = 1'b1; end
      6'h0E:   begin i_alu = ALU_XOR; i_zext = 1'b1; end
      default: i_alu = ALU_ADD;
    endcase
  end

  // Next-state and Moore outputs; write strobes are killed while rst is high.
  always_comb begin
    nxt               = st;
    bus.ir_write      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 2'b00;
    bus.pc_src        = 2'b00;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.ext_op        = 1'b0;
    bus.alu_control   = ALU_ADD;
    case (st)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        if (done) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          nxt          = DECODE;
        end else if (timeout) begin
          nxt = ERROR;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (op)
          6'h00:                             nxt = (fn == 6'h08) ? JR :
                                                   (r_legal ? EXEC_R : ERROR);
          6'h23, 6'h2B:                      nxt = MEMADR;
          6'h04, 6'h05:                      nxt = BRANCH;
          6'h08, 6'h09, 6'h0A,
          6'h0C, 6'h0D, 6'h0E:               nxt = EXEC_I;
          6'h02:                             nxt = JUMP;
          6'h03:                             nxt = JAL;
          default:                           nxt = ERROR;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        nxt = (op == 6'h23) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
        if (done)         nxt = MEMWB;
        else if (timeout) nxt = ERROR;
      end
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        if (done)         nxt = FETCH;
        else if (timeout) nxt = ERROR;
      end
      EXEC_R: begin
        bus.alu_src_a   = r_shift ? 2'b10 : 2'b01;
        bus.alu_control = r_alu;
        nxt = ALU_WB;
      end
      EXEC_I: begin
        bus.alu_src_a   = 2'b01;
        bus.alu_src_b   = 2'b10;
        bus.ext_op      = i_zext;
        bus.alu_control = i_alu;
        nxt = ALU_WB;
      end
      ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (op == 6'h00) ? 2'b01 : 2'b00;
        nxt = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 2'b01;
        bus.alu_control   = ALU_SUB;
        bus.pc_src        = 2'b01;
        bus.pc_write_cond = (op == 6'h05) ? 2'b10 : 2'b01;
        nxt = FETCH;
      end
      JUMP: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
        nxt = FETCH;
      end
      JAL: begin
        bus.pc_src    = 2'b10;
        bus.pc_write  = 1'b1;
        bus.reg_dst   = 2'b10;
        bus.reg_write = 1'b1;
        nxt = FETCH;
      end
      JR: begin
        bus.pc_src   = 2'b11;
        bus.pc_write = 1'b1;
        nxt = FETCH;
      end
      ERROR:   nxt = ERROR;
      default: nxt = ERROR;
    endcase
    if (rst) begin
      bus.ir_write      = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 2'b00;
      bus.reg_write     = 1'b0;
    end
  end

  // State, wait counter and sticky error; the counter runs only while an
  // access is outstanding, so it is zero on entry to every memory state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= FETCH;
      cnt   <= 8'd0;
      err_q <= 1'b0;
    end else begin
      st  <= nxt;
      cnt <= (mem_st && !done && !timeout) ? cnt + 8'd1 : 8'd0;
      if (nxt == ERROR) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: four instances (fixed latency 3 and 1, handshake
// with timeout 4, handshake without timeout) each run a cycle-by-cycle trace
// produced by a reference model of the instruction timing rules.
module tb_mips_mc_control;
  localparam int NDUT = 4;

  localparam logic [6:0] S_IRW = 7'b1000000;
  localparam logic [6:0] S_MR  = 7'b0100000;
  localparam logic [6:0] S_MW  = 7'b0010000;
  localparam logic [6:0] S_PCW = 7'b0001000;
  localparam logic [6:0] S_BNE = 7'b0000100;
  localparam logic [6:0] S_BEQ = 7'b0000010;
  localparam logic [6:0] S_RW  = 7'b0000001;

  localparam logic [14:0] C_IO  = 15'h4000;
  localparam logic [14:0] C_PS  = 15'h3000;
  localparam logic [14:0] C_A   = 15'h0C00;
  localparam logic [14:0] C_B   = 15'h0300;
  localparam logic [14:0] C_RD  = 15'h00C0;
  localparam logic [14:0] C_M2R = 15'h0020;
  localparam logic [14:0] C_EXT = 15'h0010;
  localparam logic [14:0] C_ALU = 15'h000F;

  localparam logic [5:0] OPS [14] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                      6'h08, 6'h0A, 6'h0C, 6'h0E, 6'h02, 6'h03, 6'h3F};
  localparam logic [5:0] FNS [14] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                                      6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01};

  // One cycle: inputs to apply and the outputs expected in that cycle.
  typedef struct packed {
    logic        rst;
    logic [31:0] instr;
    logic        rdy;
    logic [6:0]  strb;
    logic        err;
    logic [14:0] mux;
    logic [14:0] care;
  } cyc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  bit   go = 1'b0;
  bit   done [NDUT];
  cyc_t sq [NDUT][$];
  cyc_t eq [NDUT][$];
  cyc_t tq [$];
  bit   force_to = 1'b0;
  int   force_w  = -1;

  mips_mc_control_if bus [NDUT] ();

  function automatic logic [14:0] mx(logic io, logic [1:0] ps, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] rd, logic m2, logic ex, logic [3:0] alu);
    return {io, ps, a, b, rd, m2, ex, alu};
  endfunction

  function automatic void emit(logic r, logic [31:0] ins, logic rdy, logic [6:0] s,
                               logic e, logic [14:0] m, logic [14:0] cr);
    cyc_t c;
    c.rst = r; c.instr = ins; c.rdy = rdy; c.strb = s; c.err = e; c.mux = m; c.care = cr;
    tq.push_back(c);
  endfunction

  // R-type funct -> ALU code; returns 0 for an undefined funct.
  function automatic bit r_op(logic [5:0] fn, output logic [3:0] a);
    a = 4'b0010;
    case (fn)
      6'h20, 6'h21: a = 4'b0010;
      6'h22, 6'h23: a = 4'b0110;
      6'h24: a = 4'b0000;
      6'h25: a = 4'b0001;
      6'h26: a = 4'b1101;
      6'h27: a = 4'b1100;
      6'h2A: a = 4'b0111;
      6'h00: a = 4'b1000;
      6'h02: a = 4'b1001;
      6'h03: a = 4'b1010;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // One memory access (kind 0 fetch, 1 read, 2 write); returns 0 on timeout.
  function automatic bit acc(int g, logic [31:0] ins, int kind);
    logic [6:0]  base, fin;
    logic [14:0] m, cr;
    int w;
    base = (kind == 2) ? S_MW : S_MR;
    fin  = (kind == 0) ? (S_IRW | S_PCW) : 7'd0;
    if (kind == 0) begin
      m  = mx(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 4'b0010);
      cr = C_IO | C_PS | C_A | C_B | C_ALU;
    end else begin
      m  = mx(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0);
      cr = C_IO;
    end
    if (g == 0 || g == 3) begin
      w = (g == 0) ? 2 : 0;
      for (int k = 0; k < w; k++) emit(1'b0, ins, 1'($urandom), base, 1'b0, m, cr);
      emit(1'b0, ins, 1'($urandom), base | fin, 1'b0, m, cr);
      return 1'b1;
    end
    if (g == 1 && (force_to || $urandom_range(0, 11) == 0)) begin
      force_to = 1'b0;
      for (int k = 0; k < 5; k++) emit(1'b0, ins, 1'b0, base, 1'b0, m, cr);
      return 1'b0;
    end
    if (kind == 2 && force_w >= 0) begin
      w = force_w;
      force_w = -1;
    end else begin
      w = (g == 1) ? $urandom_range(0, 4) : $urandom_range(0, 7);
    end
    for (int k = 0; k < w; k++) emit(1'b0, ins, 1'b0, base, 1'b0, m, cr);
    emit(1'b0, ins, 1'b1, base | fin, 1'b0, m, cr);
    return 1'b1;
  endfunction

  // Full trace of one instruction; abort >= 0 replaces that cycle with a reset.
  function automatic void gen(int g, logic [31:0] ins, int abort);
    logic [5:0] op, fn;
    logic [3:0] a;
    bit ok;
    cyc_t c;
    op = ins[31:26];
    fn = ins[5:0];
    tq.delete();
    ok = acc(g, ins, 0);
    if (ok) begin
      emit(1'b0, ins, 1'($urandom), 7'd0, 1'b0,
           mx(1'b0, 2'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 4'b0010), C_A | C_B | C_ALU);
      case (op)
        6'h00: begin
          if (fn == 6'h08) begin
            emit(1'b0, ins, 1'b0, S_PCW, 1'b0, mx(1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0), C_PS);
          end else if (r_op(fn, a)) begin
            if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)
              emit(1'b0, ins, 1'b0, 7'd0, 1'b0, mx(1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, a), C_A | C_ALU);
            else
              emit(1'b0, ins, 1'b0, 7'd0, 1'b0, mx(1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, a), C_A | C_B | C_ALU);
            emit(1'b0, ins, 1'b0, S_RW, 1'b0, mx(1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 4'd0), C_RD | C_M2R);
          end else begin
            ok = 1'b0;
          end
        end
        6'h23, 6'h2B: begin
          emit(1'b0, ins, 1'b0, 7'd0, 1'b0, mx(1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 4'b0010), C_A | C_B | C_ALU);
          ok = acc(g, ins, (op == 6'h23) ? 1 : 2);
          if (ok && op == 6'h23)
            emit(1'b0, ins, 1'b0, S_RW, 1'b0, mx(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0), C_RD | C_M2R);
        end
        6'h04, 6'h05:
          emit(1'b0, ins, 1'b0, (op == 6'h05) ? S_BNE : S_BEQ, 1'b0,
               mx(1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0110), C_PS | C_A | C_B | C_ALU);
        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
          case (op)
            6'h0A:   a = 4'b0111;
            6'h0C:   a = 4'b0000;
            6'h0D:   a = 4'b0001;
            6'h0E:   a = 4'b1101;
            default: a = 4'b0010;
          endcase
          emit(1'b0, ins, 1'b0, 7'd0, 1'b0, mx(1'b0, 2'd0, 2'd1, 2'd2, 2'd0, 1'b0, op >= 6'h0C, a),
               C_A | C_B | C_EXT | C_ALU);
          emit(1'b0, ins, 1'b0, S_RW, 1'b0, mx(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0), C_RD | C_M2R);
        end
        6'h02: emit(1'b0, ins, 1'b0, S_PCW, 1'b0, mx(1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'd0), C_PS);
        6'h03: emit(1'b0, ins, 1'b0, S_PCW | S_RW, 1'b0,
                    mx(1'b0, 2'd2, 2'd0, 2'd0, 2'd2, 1'b0, 1'b0, 4'd0), C_PS | C_RD);
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      repeat ($urandom_range(1, 3)) emit(1'b0, ins, 1'($urandom), 7'd0, 1'b1, 15'd0, 15'd0);
      emit(1'b1, ins, 1'($urandom), 7'd0, 1'b1, 15'd0, 15'd0);
    end
    if (abort >= 0 && abort < tq.size()) begin
      c = tq[abort];
      c.rst = 1'b1; c.strb = 7'd0; c.care = 15'd0;
      while (tq.size() > abort) void'(tq.pop_back());
      tq.push_back(c);
    end
    foreach (tq[i]) sq[g].push_back(tq[i]);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    i[31:26] = OPS[$urandom_range(0, 13)];
    if (i[31:26] == 6'h00) i[5:0] = FNS[$urandom_range(0, 13)];
    return i;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gd
    logic rst;
    int   ncyc = 0;

    mips_mc_control #(
      .MEM_HANDSHAKE((g == 1 || g == 2) ? 1 : 0),
      .MEM_LATENCY  ((g == 0) ? 3 : 1),
      .TIMEOUT      ((g == 1) ? 4 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );

    // Driver: applies one trace entry per cycle and hands its expectation on.
    initial begin
      cyc_t c;
      rst = 1'b1;
      bus[g].instr = '0;
      bus[g].mem_ready = 1'b0;
      done[g] = 1'b0;
      wait (go);
      while (sq[g].size() > 0) begin
        @(negedge clk);
        c = sq[g].pop_front();
        rst = c.rst;
        bus[g].instr = c.instr;
        bus[g].mem_ready = c.rdy;
        eq[g].push_back(c);
      end
      done[g] = 1'b1;
    end

    // Monitor: compares outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
      cyc_t        e;
      logic [6:0]  s;
      logic [14:0] m;
      #2;
      if (eq[g].size() > 0) begin
        e = eq[g].pop_front();
        s = {bus[g].ir_write, bus[g].mem_read, bus[g].mem_write, bus[g].pc_write,
             bus[g].pc_write_cond, bus[g].reg_write};
        m = {bus[g].iord, bus[g].pc_src, bus[g].alu_src_a, bus[g].alu_src_b, bus[g].reg_dst,
             bus[g].mem_to_reg, bus[g].ext_op, bus[g].alu_control};
        checks++;
        if (s !== e.strb) begin
          failures++;
          $display("FAIL dut%0d cyc%0d strobes got=%b exp=%b instr=%h", g, ncyc, s, e.strb, e.instr);
        end
        checks++;
        if (bus[g].error !== e.err) begin
          failures++;
          $display("FAIL dut%0d cyc%0d error got=%b exp=%b instr=%h", g, ncyc, bus[g].error, e.err, e.instr);
        end
        if (e.care != 15'd0) begin
          checks++;
          if ((m & e.care) !== (e.mux & e.care)) begin
            failures++;
            $display("FAIL dut%0d cyc%0d selects got=%h exp=%h mask=%h instr=%h",
                     g, ncyc, m & e.care, e.mux & e.care, e.care, e.instr);
          end
        end
        ncyc++;
      end
    end
  end

  initial begin
    bit all;
    for (int g = 0; g < NDUT; g++) begin
      tq.delete();
      emit(1'b1, 32'd0, 1'b0, 7'd0, 1'b0, 15'd0, 15'd0);
      foreach (tq[i]) sq[g].push_back(tq[i]);
      gen(g, 32'h012A4020, -1);
      gen(g, 32'h8D280004, -1);
      if (g == 2) force_w = 5;
      gen(g, 32'hAD280004, -1);
      gen(g, 32'h15090003, -1);
      gen(g, 32'h0C001000, -1);
      gen(g, 32'h03E00008, -1);
      gen(g, 32'h3100FFFF, -1);
      gen(g, 32'hFC000000, -1);
      gen(g, 32'h8D280004, 6);
      if (g == 1) force_to = 1'b1;
      gen(g, 32'h012A4020, -1);
      for (int n = 0; n < 50; n++)
        gen(g, rand_instr(), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1);
    end
    go = 1'b1;
    all = 1'b0;
    for (int t = 0; t < 40000 && !all; t++) begin
      @(posedge clk);
      all = 1'b1;
      for (int g = 0; g < NDUT; g++) if (!done[g]) all = 1'b0;
    end
    checks++;
    if (!all) begin
      failures++;
      $display("FAIL run_budget got=unfinished exp=all traces applied");
    end
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Parametrised multicycle MIPS control unit: Moore FSM driving the datapath strobes and mux selects of the multicycle core.
- Adds a memory wait-state mechanism, selectable as fixed latency or ready handshake, with a timeout error trap.
- Adds jal/jr/bne, shifts, xor/nor and zero-extended logical immediates.
- Sits between the instruction register and the ALU, register file, PC and memory muxes.

Parameters:
- MEM_HANDSHAKE, 0: 0 = fixed-latency memory; 1 = wait for mem_ready.
- MEM_LATENCY, 1: cycles per memory access when MEM_HANDSHAKE=0; legal range 1..255.
- TIMEOUT, 255: maximum wait cycles per access when MEM_HANDSHAKE=1; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- instr  in  32  instruction register contents.
- mem_ready  in  1  memory access complete this cycle; used only when MEM_HANDSHAKE=1.
- ir_write  out  1  load instruction register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  2  PC load condition: [0] = load if zero, [1] = load if not zero.
- pc_src  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = register A.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = A, 10 = shamt.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext, 11 = ext<<2.
- reg_dst  out  2  write address select: 00 = rt, 01 = rd, 10 = r31 (write data = PC).
- mem_to_reg  out  1  register write data = MDR.
- reg_write  out  1  register file write enable.
- ext_op  out  1  1 = zero-extend the immediate.
- alu_control  out  4  ALU operation code.
- state  out  4  current state, for debug.
- error  out  1  sticky; set on illegal opcode or timeout.

Behaviour:
- Reset (rst high): on the next edge, state <= FETCH, wait counter and error cleared. Every write strobe (ir_write, mem_write, pc_write, pc_write_cond, reg_write) and mem_read is forced to 0 during any cycle with rst high. Reset wins over all other events, including a pending memory access or the ERROR state.
- Outputs: decoded from state and instr only, with one exception: the access-complete qualifier on ir_write and pc_write in FETCH. No registered outputs except state and error.
- alu_control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, XOR 1101, NOR 1100, SLL 1000, SRL 1001, SRA 1010.
- Memory states are FETCH, MEMRD and MEMWR. An access is complete when:
  - MEM_HANDSHAKE=0: the wait counter equals MEM_LATENCY-1.
  - MEM_HANDSHAKE=1: mem_ready is high.
  - The counter is 8 bits, clears on entry to any memory state, and increments each cycle until the access completes.
  - mem_read or mem_write is held high for every cycle of the access.
- FETCH: iord=0, alu_src_a=00, alu_src_b=01, alu ADD, pc_src=00. ir_write and pc_write assert only in the completing cycle. Next state is DECODE on completion.
- DECODE: ALUOut <= PC + (ext<<2) (alu_src_a=00, alu_src_b=11, ADD). Dispatch on opcode:
  - R-type: funct 08 -> JR, other legal funct -> EXEC_R.
  - lw (23), sw (2B) -> MEMADR.
  - beq (04), bne (05) -> BRANCH.
  - addi (08), addiu (09), slti (0A), andi (0C), ori (0D), xori (0E) -> EXEC_I.
  - j (02) -> JUMP; jal (03) -> JAL.
  - Anything else -> ERROR.
- MEMADR: A + ext, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next MEMWB on completion.
- MEMWB: reg_dst=00, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWR: iord=1. Next FETCH on completion.
- EXEC_R: operation decoded from funct:
  - 20/21 -> ADD, 22/23 -> SUB, 24 -> AND, 25 -> OR, 26 -> XOR, 27 -> NOR, 2A -> SLT.
  - 00/02/03 -> SLL/SRL/SRA with alu_src_a=10.
  - Other legal funct: alu_src_a=01, alu_src_b=00.
  - Next ALU_WB; write uses reg_dst=01.
- EXEC_I: alu_src_a=01, alu_src_b=10. ext_op=1 for andi/ori/xori, else 0. Next ALU_WB; write uses reg_dst=00.
- ALU_WB: reg_write=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=01, alu_src_b=00, SUB, pc_src=01. pc_write_cond=01 for beq, 10 for bne. Next FETCH.
- JUMP: pc_src=10, pc_write=1. Next FETCH.
- JAL: reg_dst=10, reg_write=1, pc_src=10, pc_write=1 in the same cycle; the datapath writes the old PC+4. Next FETCH.
- JR: pc_src=11, pc_write=1. Next FETCH.
- ERROR: all strobes 0, error=1; holds until rst.
- Timeout: when MEM_HANDSHAKE=1 and TIMEOUT>0, the counter reaching TIMEOUT without mem_ready -> ERROR on the next edge. mem_ready high in that same cycle wins (access completes).
- Cycle counts, with L = access cycles:
  - R-type and I-type ALU ops: L+3.
  - lw: 2L+3.
  - sw: 2L+2.
  - Branch, j, jal, jr: L+2.

Test Plan:
- MEM_HANDSHAKE=0, MEM_LATENCY=1; instr 0x012A4020 (add $8,$9,$10) -> states FETCH,DECODE,EXEC_R,ALU_WB; one reg_write with reg_dst=01 and alu_control=0010; 4 cycles total.
- MEM_LATENCY=3; lw 0x8D280004 -> mem_read high 3 cycles in FETCH and 3 in MEMRD; ir_write exactly once; mem_to_reg=1 and reg_write in MEMWB; 9 cycles total.
- MEM_HANDSHAKE=1; sw with mem_ready low for 5 cycles then high -> mem_write high 6 consecutive cycles; return to FETCH the next cycle; error stays 0.
- MEM_HANDSHAKE=1, TIMEOUT=4; mem_ready held low in FETCH -> ERROR entered after counter=4; error=1 and strobes 0; asserting rst returns state to FETCH and clears error.
- bne 0x15090003, then jal 0x0C001000, then jr $31 -> pc_write_cond=10 with pc_src=01; JAL with reg_dst=10, reg_write=1, pc_src=10 in one cycle; JR with pc_src=11.
- Illegal opcode 0x3F -> DECODE goes to ERROR; rst asserted mid-MEMRD -> no strobes that cycle, FETCH next.
